// File: rtl/rle_decomp_pkg.sv
// ---------------------------------------------------------------------------
// rle_decomp_pkg
//   Shared definitions for the run-length stream decompressor.
//   - default width constants (RAM word, RAM address, code)
//   - state_t : controller states (IDLE, RUN, RD, MERGE, WR, DONE)
//   - code_val / code_len : split a code into its bit value (MSB) and its
//     run length (remaining low bits). Codes are passed zero-extended to 32
//     bits together with the real code width so one helper serves any width.
// ---------------------------------------------------------------------------
package rle_decomp_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_CODE_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    RD    = 3'd2,
    MERGE = 3'd3,
    WR    = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Bit value carried by the code (its MSB).
  function automatic logic code_val(input logic [31:0] c, input int cw);
    return ((c >> (cw - 1)) & 32'd1) != 32'd0;
  endfunction

  // Run length carried by the code (all bits below the MSB).
  function automatic logic [31:0] code_len(input logic [31:0] c, input int cw);
    return c & ((32'd1 << (cw - 1)) - 32'd1);
  endfunction

endpackage

// File: rtl/rle_bit_packer.sv
// ---------------------------------------------------------------------------
// rle_bit_packer
//   Combinational fill generator. Marks the n bits starting at i_bit_idx and
//   going down, i.e. bits [i_bit_idx : i_bit_idx-i_n+1], and produces the
//   matching data pattern for a run of value i_run_val.
//   Callers guarantee i_n <= i_bit_idx+1, so the range never leaves the word.
//
// Ports
//   i_bit_idx  in   BIDX_W   highest bit to fill
//   i_n        in   BIDX_W+1 number of bits to fill (0..DATA_W)
//   i_run_val  in   1        value written into the filled bits
//   o_mask     out  DATA_W   1 for every bit covered by the fill
//   o_bits     out  DATA_W   fill data (o_mask when i_run_val, else 0)
// ---------------------------------------------------------------------------
module rle_bit_packer
  import rle_decomp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int BIDX_W = $clog2(DATA_W)
) (
  input  logic [BIDX_W-1:0] i_bit_idx,
  input  logic [BIDX_W:0]   i_n,
  input  logic              i_run_val,
  output logic [DATA_W-1:0] o_mask,
  output logic [DATA_W-1:0] o_bits
);

  localparam int N_W = BIDX_W + 1;

  logic [N_W-1:0] w_top;

  assign w_top = {1'b0, i_bit_idx};

  // Bit i is covered when it is at or below the top bit and within n of it:
  // i <= top and i > top - n, rewritten as i + n > top to stay unsigned.
  always_comb begin
    o_mask = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if ((N_W'(i) <= w_top) && ((N_W'(i) + i_n) > w_top)) begin
        o_mask[i] = 1'b1;
      end
    end
    o_bits = i_run_val ? o_mask : '0;
  end

endmodule

// File: rtl/rle_stream_decompressor.sv
// ---------------------------------------------------------------------------
// rle_stream_decompressor
//   Expands a valid/ready stream of run-length codes into a bit stream and
//   packs it MSB-first into DATA_W-bit RAM words, starting at start_addr /
//   start_bit. Full words are written directly; a word only partly produced
//   by this job (first and/or last) is merged with the existing RAM contents
//   by read-modify-write. Words with no bits produced are never touched.
//
// Handshake: a code transfers on a rising clk edge where code_valid and
//   code_ready are both 1. code_ready depends only on internal state, never
//   on code_valid; the producer holds code stable while valid and not ready.
//
// Optional build macro RLE_DECOMP_STATS_EN adds the bit_count and
//   words_written statistics outputs.
//
// Ports
//   clk           in   1       clock
//   RST           in   1       synchronous active-low reset
//   start         in   1       begin a job (ignored unless idle)
//   start_addr    in   ADDR_W  first word address
//   start_bit     in   BIDX_W  first bit to write (DATA_W-1 = word aligned)
//   code_valid    in   1       code present
//   code_ready    out  1       code accepted when valid & ready
//   code          in   CODE_W  MSB = bit value, low bits = run length
//   flush         in   1       level: end the job once no code is pending
//   busy          out  1       job in progress
//   done          out  1       one-cycle pulse at job end
//   end_addr      out  ADDR_W  next word to write (held until next start)
//   end_bit       out  BIDX_W  next bit to write (held until next start)
//   ram_addr      out  ADDR_W  RAM address
//   ram_wdata     out  DATA_W  RAM write data
//   ram_rdata     in   DATA_W  RAM read data, valid 1 cycle after ram_rd
//   ram_rd        out  1       read strobe
//   ram_wr        out  1       write strobe
//   bit_count     out  32      (stats build) bits produced this job
//   words_written out  ADDR_W  (stats build) RAM writes this job
//   dbg_state     out  state_t current controller state
//
// Timing note: every output is a flop. Read/write strobes are registered on
// entry to RD / WR so they are visible during those states. The merge write
// needs ram_rdata, which is only valid during MERGE, so its strobe and data
// are registered at the end of MERGE and appear in the following cycle.
// ---------------------------------------------------------------------------
module rle_stream_decompressor
  import rle_decomp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CODE_W = DEF_CODE_W,
  parameter int BIDX_W = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [BIDX_W-1:0] start_bit,
  input  logic              code_valid,
  output logic              code_ready,
  input  logic [CODE_W-1:0] code,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] end_addr,
  output logic [BIDX_W-1:0] end_bit,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_rd,
  output logic              ram_wr,
`ifdef RLE_DECOMP_STATS_EN
  output logic [31:0]       bit_count,
  output logic [ADDR_W-1:0] words_written,
`endif
  output state_t            dbg_state
);

  localparam int RUN_W = CODE_W - 1;
  localparam int N_W   = BIDX_W + 1;
  localparam logic [BIDX_W-1:0] TOP_BIT = BIDX_W'(DATA_W - 1);

  // State and datapath registers
  state_t            r_state, nxt_state;
  logic [ADDR_W-1:0] r_cur_addr, nxt_cur_addr;
  logic [BIDX_W-1:0] r_bit_idx, nxt_bit_idx;
  logic [DATA_W-1:0] r_word_buf, nxt_word_buf;
  logic [DATA_W-1:0] r_mask, nxt_mask;
  logic              r_run_val, nxt_run_val;
  logic [RUN_W-1:0]  r_run_left, nxt_run_left;
  logic              r_full, nxt_full;     // bit 0 of the current word filled

  // Registered outputs
  logic              r_busy, nxt_busy;
  logic              r_done, nxt_done;
  logic              r_code_ready, nxt_code_ready;
  logic              r_ram_rd, nxt_ram_rd;
  logic              r_ram_wr, nxt_ram_wr;
  logic [ADDR_W-1:0] r_ram_addr, nxt_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata, nxt_ram_wdata;
  logic [ADDR_W-1:0] r_end_addr, nxt_end_addr;
  logic [BIDX_W-1:0] r_end_bit, nxt_end_bit;

  // Datapath wires
  logic [N_W-1:0]    w_room;       // bits still free in the word
  logic [N_W-1:0]    w_n;          // bits filled this cycle
  logic              w_hit_bit0;   // this fill reaches bit 0
  logic [DATA_W-1:0] w_fill_mask;
  logic [DATA_W-1:0] w_fill_bits;
  logic [DATA_W-1:0] w_fill_buf;
  logic [DATA_W-1:0] w_fill_mask_all;
  logic [DATA_W-1:0] w_merge;
  logic              w_accept;
  logic              w_flush_go;
  logic              w_code_val;
  logic [RUN_W-1:0]  w_code_len;

  assign w_room = {1'b0, r_bit_idx} + N_W'(1);
  // n = min(run_left, bit_idx+1); the narrowing cast only applies when
  // run_left is smaller than the room, so it never loses bits.
  assign w_n        = (32'(r_run_left) < 32'(w_room)) ? N_W'(r_run_left) : w_room;
  assign w_hit_bit0 = (w_n == w_room);

  rle_bit_packer #(
    .DATA_W (DATA_W),
    .BIDX_W (BIDX_W)
  ) u_packer (
    .i_bit_idx (r_bit_idx),
    .i_n       (w_n),
    .i_run_val (r_run_val),
    .o_mask    (w_fill_mask),
    .o_bits    (w_fill_bits)
  );

  assign w_fill_buf      = (r_word_buf & ~w_fill_mask) | w_fill_bits;
  assign w_fill_mask_all = r_mask | w_fill_mask;
  assign w_merge         = (r_word_buf & r_mask) | (ram_rdata & ~r_mask);

  assign w_accept   = code_valid && r_code_ready;
  // A pending code always beats flush; flush also waits for the run to drain.
  assign w_flush_go = flush && !code_valid && (r_run_left == '0);

  assign w_code_val = code_val(32'(code), CODE_W);
  assign w_code_len = RUN_W'(code_len(32'(code), CODE_W));

  // Next-state / next-output logic
  always_comb begin
    nxt_state      = r_state;
    nxt_cur_addr   = r_cur_addr;
    nxt_bit_idx    = r_bit_idx;
    nxt_word_buf   = r_word_buf;
    nxt_mask       = r_mask;
    nxt_run_val    = r_run_val;
    nxt_run_left   = r_run_left;
    nxt_full       = r_full;
    nxt_ram_rd     = 1'b0;
    nxt_ram_wr     = 1'b0;
    nxt_ram_addr   = r_ram_addr;
    nxt_ram_wdata  = r_ram_wdata;
    nxt_end_addr   = r_end_addr;
    nxt_end_bit    = r_end_bit;
    nxt_busy       = 1'b0;
    nxt_done       = 1'b0;
    nxt_code_ready = 1'b0;

    case (r_state)
      IDLE: begin
        if (start) begin
          nxt_state    = RUN;
          nxt_cur_addr = start_addr;
          nxt_bit_idx  = start_bit;
          nxt_word_buf = '0;
          nxt_mask     = '0;
          nxt_run_left = '0;
          nxt_full     = 1'b0;
        end
      end

      RUN: begin
        if (r_run_left != '0) begin
          nxt_word_buf = w_fill_buf;
          nxt_mask     = w_fill_mask_all;
          nxt_run_left = r_run_left - RUN_W'(w_n);
          if (w_hit_bit0) begin
            // Word complete: fully produced -> plain write, else RMW.
            nxt_full     = 1'b1;
            nxt_ram_addr = r_cur_addr;
            if (w_fill_mask_all == '1) begin
              nxt_state     = WR;
              nxt_ram_wr    = 1'b1;
              nxt_ram_wdata = w_fill_buf;
            end else begin
              nxt_state  = RD;
              nxt_ram_rd = 1'b1;
            end
          end else begin
            nxt_bit_idx = r_bit_idx - BIDX_W'(w_n);
          end
        end else if (w_accept) begin
          // Zero-length codes land here too and leave run_left at 0.
          nxt_run_val  = w_code_val;
          nxt_run_left = w_code_len;
        end else if (w_flush_go) begin
          if (r_mask != '0) begin
            nxt_state    = RD;
            nxt_ram_rd   = 1'b1;
            nxt_ram_addr = r_cur_addr;
          end else begin
            nxt_state = DONE;
          end
        end
      end

      WR: begin
        nxt_cur_addr = r_cur_addr + ADDR_W'(1);
        nxt_bit_idx  = TOP_BIT;
        nxt_mask     = '0;
        nxt_word_buf = '0;
        nxt_full     = 1'b0;
        nxt_state    = w_flush_go ? DONE : RUN;
      end

      RD: begin
        nxt_state = MERGE;
      end

      MERGE: begin
        nxt_ram_wr    = 1'b1;
        nxt_ram_wdata = w_merge;
        if (r_full) begin
          nxt_cur_addr = r_cur_addr + ADDR_W'(1);
          nxt_bit_idx  = TOP_BIT;
          nxt_mask     = '0;
          nxt_word_buf = '0;
          nxt_full     = 1'b0;
          nxt_state    = w_flush_go ? DONE : RUN;
        end else begin
          // Flush of a partial word: position stays on this word.
          nxt_state = DONE;
        end
      end

      DONE: begin
        nxt_state = IDLE;
      end

      default: begin
        nxt_state = IDLE;
      end
    endcase

    nxt_busy       = (nxt_state == RUN) || (nxt_state == RD) ||
                     (nxt_state == MERGE) || (nxt_state == WR);
    nxt_done       = (nxt_state == DONE);
    nxt_code_ready = (nxt_state == RUN) && (nxt_run_left == '0);
    if ((nxt_state == DONE) && (r_state != DONE)) begin
      nxt_end_addr = nxt_cur_addr;
      nxt_end_bit  = nxt_bit_idx;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= nxt_state;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!RST) begin
      r_cur_addr   <= '0;
      r_bit_idx    <= TOP_BIT;
      r_word_buf   <= '0;
      r_mask       <= '0;
      r_run_val    <= 1'b0;
      r_run_left   <= '0;
      r_full       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_code_ready <= 1'b0;
      r_ram_rd     <= 1'b0;
      r_ram_wr     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
      r_end_addr   <= '0;
      r_end_bit    <= TOP_BIT;
    end else begin
      r_cur_addr   <= nxt_cur_addr;
      r_bit_idx    <= nxt_bit_idx;
      r_word_buf   <= nxt_word_buf;
      r_mask       <= nxt_mask;
      r_run_val    <= nxt_run_val;
      r_run_left   <= nxt_run_left;
      r_full       <= nxt_full;
      r_busy       <= nxt_busy;
      r_done       <= nxt_done;
      r_code_ready <= nxt_code_ready;
      r_ram_rd     <= nxt_ram_rd;
      r_ram_wr     <= nxt_ram_wr;
      r_ram_addr   <= nxt_ram_addr;
      r_ram_wdata  <= nxt_ram_wdata;
      r_end_addr   <= nxt_end_addr;
      r_end_bit    <= nxt_end_bit;
    end
  end

`ifdef RLE_DECOMP_STATS_EN
  logic [31:0]       r_bit_count;
  logic [ADDR_W-1:0] r_words_written;

  always_ff @(posedge clk) begin
    if (!RST) begin
      r_bit_count     <= '0;
      r_words_written <= '0;
    end else if ((r_state == IDLE) && start) begin
      r_bit_count     <= '0;
      r_words_written <= '0;
    end else begin
      if ((r_state == RUN) && (r_run_left != '0)) begin
        r_bit_count <= r_bit_count + 32'(w_n);
      end
      if (nxt_ram_wr) begin
        r_words_written <= r_words_written + ADDR_W'(1);
      end
    end
  end

  assign bit_count     = r_bit_count;
  assign words_written = r_words_written;
`endif

  assign busy       = r_busy;
  assign done       = r_done;
  assign code_ready = r_code_ready;
  assign ram_rd     = r_ram_rd;
  assign ram_wr     = r_ram_wr;
  assign ram_addr   = r_ram_addr;
  assign ram_wdata  = r_ram_wdata;
  assign end_addr   = r_end_addr;
  assign end_bit    = r_end_bit;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_rle_stream_decompressor.sv
// ---------------------------------------------------------------------------
// tb_rle_stream_decompressor
//   Directed jobs from the test plan plus a few random jobs. Expected RAM
//   reads and writes are pushed to queues when a job is set up and popped
//   as the DUT issues strobes. Random jobs get their expectations from a
//   bit-by-bit packing model working on the bench RAM contents.
// ---------------------------------------------------------------------------
module tb_rle_stream_decompressor;
  import rle_decomp_pkg::*;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int CODE_W = 8;
  localparam int BIDX_W = 4;

  logic              clk;
  logic              RST;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [BIDX_W-1:0] start_bit;
  logic              code_valid;
  logic              code_ready;
  logic [CODE_W-1:0] code;
  logic              flush;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] end_addr;
  logic [BIDX_W-1:0] end_bit;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_rd;
  logic              ram_wr;
  state_t            dbg_state;

  int errors = 0;
  int checks = 0;

  logic [31:0]       exp_wr_q[$];   // {addr, data}
  logic [ADDR_W-1:0] exp_rd_q[$];
  logic [CODE_W-1:0] code_q[$];
  logic              chk_ready_on_wr = 1'b0;

  // Bench RAM with preload port
  logic [DATA_W-1:0] mem [0:65535];
  logic              pre_we = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [DATA_W-1:0] pre_data = '0;

  rle_stream_decompressor #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .CODE_W (CODE_W)
  ) dut (
    .clk        (clk),
    .RST        (RST),
    .start      (start),
    .start_addr (start_addr),
    .start_bit  (start_bit),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .code       (code),
    .flush      (flush),
    .busy       (busy),
    .done       (done),
    .end_addr   (end_addr),
    .end_bit    (end_bit),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .ram_rd     (ram_rd),
    .ram_wr     (ram_wr),
    .dbg_state  (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_rd) ram_rdata <= mem[ram_addr];
    if (ram_wr) mem[ram_addr] <= ram_wdata;
    if (pre_we) mem[pre_addr] <= pre_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: compare every strobe against the expected queues
  logic [31:0]       mon_w;
  logic [ADDR_W-1:0] mon_r;
  always @(negedge clk) begin
    if (ram_wr) begin
      check("wr_expected", 32'(exp_wr_q.size() != 0), 32'd1);
      if (exp_wr_q.size() != 0) begin
        mon_w = exp_wr_q.pop_front();
        check("wr_addr_data", {ram_addr, ram_wdata}, mon_w);
      end
      if (chk_ready_on_wr) check("ready_low_in_wr", 32'(code_ready), 32'd0);
    end
    if (ram_rd) begin
      check("rd_expected", 32'(exp_rd_q.size() != 0), 32'd1);
      if (exp_rd_q.size() != 0) begin
        mon_r = exp_rd_q.pop_front();
        check("rd_addr", 32'(ram_addr), 32'(mon_r));
      end
    end
  end

  // Driver tasks
  task automatic poke(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] a, input logic [BIDX_W-1:0] b);
    start = 1'b1; start_addr = a; start_bit = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offers one code and returns just after the accepting edge, valid still high.
  task automatic send_code(input logic [CODE_W-1:0] c);
    bit acc;
    acc = 1'b0;
    code = c; code_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (code_ready) begin
        @(posedge clk); #1;
        acc = 1'b1;
        break;
      end
    end
    check("code_accepted", 32'(acc), 32'd1);
  endtask

  task automatic wait_done(input logic [ADDR_W-1:0] ea, input logic [BIDX_W-1:0] eb);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    if (seen) begin
      check("end_addr", 32'(end_addr), 32'(ea));
      check("end_bit", 32'(end_bit), 32'(eb));
      check("busy_at_done", 32'(busy), 32'd0);
    end
  endtask

  task automatic run_job(input logic [ADDR_W-1:0] a, input logic [BIDX_W-1:0] b,
                         input logic [ADDR_W-1:0] ea, input logic [BIDX_W-1:0] eb);
    do_start(a, b);
    foreach (code_q[k]) send_code(code_q[k]);
    code_valid = 1'b0;
    flush = 1'b1;
    wait_done(ea, eb);
    flush = 1'b0;
    code_q.delete();
    repeat (3) @(negedge clk);
    check("wr_q_drained", 32'(exp_wr_q.size()), 32'd0);
    check("rd_q_drained", 32'(exp_rd_q.size()), 32'd0);
    check("end_addr_hold", 32'(end_addr), 32'(ea));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_ready"}, 32'(code_ready), 32'd0);
    check({tag, "_rd"}, 32'(ram_rd), 32'd0);
    check({tag, "_wr"}, 32'(ram_wr), 32'd0);
    check({tag, "_addr"}, 32'(ram_addr), 32'd0);
    check({tag, "_wdata"}, 32'(ram_wdata), 32'd0);
    check({tag, "_end_addr"}, 32'(end_addr), 32'd0);
    check({tag, "_end_bit"}, 32'(end_bit), 32'd15);
    check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  // Bit-level packing model over the bench RAM contents
  logic [ADDR_W-1:0] m_end_addr;
  logic [BIDX_W-1:0] m_end_bit;
  task automatic model_job(input logic [ADDR_W-1:0] a, input logic [BIDX_W-1:0] b);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wbuf, wmask, merged;
    logic [CODE_W-1:0] c;
    int idx;
    addr = a; idx = int'(b); wbuf = '0; wmask = '0;
    foreach (code_q[k]) begin
      c = code_q[k];
      for (int j = 0; j < int'(c[6:0]); j++) begin
        wbuf[idx]  = c[7];
        wmask[idx] = 1'b1;
        if (idx == 0) begin
          if (wmask != 16'hFFFF) exp_rd_q.push_back(addr);
          merged = (wbuf & wmask) | (mem[addr] & ~wmask);
          exp_wr_q.push_back({addr, merged});
          addr = addr + 16'd1; idx = 15; wbuf = '0; wmask = '0;
        end else begin
          idx--;
        end
      end
    end
    if (wmask != '0) begin
      exp_rd_q.push_back(addr);
      merged = (wbuf & wmask) | (mem[addr] & ~wmask);
      exp_wr_q.push_back({addr, merged});
    end
    m_end_addr = addr;
    m_end_bit  = BIDX_W'(idx);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    logic [ADDR_W-1:0] ra;
    logic [BIDX_W-1:0] rb;
    bit seen;
    int nc;

    RST = 1'b0; start = 1'b0; start_addr = '0; start_bit = '0;
    code_valid = 1'b0; code = '0; flush = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    RST = 1'b1;
    repeat (2) @(negedge clk);

    // 1: one full word, no read
    code_q.push_back(8'h90);
    exp_wr_q.push_back({16'h0010, 16'hFFFF});
    run_job(16'h0010, 4'd15, 16'h0011, 4'd15);

    // 2: partial word inside a word -> single RMW
    poke(16'h0020, 16'hABCD);
    code_q.push_back(8'h84);
    exp_rd_q.push_back(16'h0020);
    exp_wr_q.push_back({16'h0020, 16'hABFD});
    run_job(16'h0020, 4'd7, 16'h0020, 4'd3);

    // 3: 40 ones from word start: two full words then a partial one
    poke(16'h0002, 16'h1234);
    code_q.push_back(8'hA8);
    exp_wr_q.push_back({16'h0000, 16'hFFFF});
    exp_wr_q.push_back({16'h0001, 16'hFFFF});
    exp_rd_q.push_back(16'h0002);
    exp_wr_q.push_back({16'h0002, 16'hFF34});
    run_job(16'h0000, 4'd15, 16'h0002, 4'd7);

    // 4: zero-length codes absorbed, back-to-back offers, ready low in WR
    chk_ready_on_wr = 1'b1;
    code_q.push_back(8'h80);
    code_q.push_back(8'h00);
    code_q.push_back(8'h08);
    code_q.push_back(8'h88);
    exp_wr_q.push_back({16'h0030, 16'h00FF});
    run_job(16'h0030, 4'd15, 16'h0031, 4'd15);
    chk_ready_on_wr = 1'b0;

    // 5: address wrap
    code_q.push_back(8'hA0);
    exp_wr_q.push_back({16'hFFFF, 16'hFFFF});
    exp_wr_q.push_back({16'h0000, 16'hFFFF});
    run_job(16'hFFFF, 4'd15, 16'h0001, 4'd15);

    // 6: reset during RD aborts the merge write
    poke(16'h0020, 16'hABCD);
    exp_rd_q.push_back(16'h0020);
    do_start(16'h0020, 4'd7);
    send_code(8'h84);
    code_valid = 1'b0;
    flush = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ram_rd) begin
        seen = 1'b1;
        break;
      end
    end
    check("rd_before_abort", 32'(seen), 32'd1);
    RST = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    check_reset_outputs("abort");
    RST = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_no_wr", 32'(exp_wr_q.size()), 32'd0);
    check("abort_ram_kept", 32'(mem[16'h0020]), 32'h0000ABCD);
    // Same job again runs normally after the abort
    code_q.push_back(8'h84);
    exp_rd_q.push_back(16'h0020);
    exp_wr_q.push_back({16'h0020, 16'hABFD});
    run_job(16'h0020, 4'd7, 16'h0020, 4'd3);

    // Random jobs checked against the packing model
    for (int a = 16'h0100; a < 16'h0220; a++) poke(16'(a), 16'($urandom));
    for (int t = 0; t < 4; t++) begin
      ra = 16'($urandom_range(16'h0100, 16'h01F0));
      rb = 4'($urandom_range(0, 15));
      nc = $urandom_range(1, 5);
      for (int k = 0; k < nc; k++) begin
        code_q.push_back({1'($urandom_range(0, 1)), 7'($urandom_range(0, 40))});
      end
      model_job(ra, rb);
      run_job(ra, rb, m_end_addr, m_end_bit);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rle_stream_decompressor.md
Name: rle_stream_decompressor

Overview:
- Parametrised successor to the fixed 16-bit decompress handler.
- Consumes a valid/ready stream of run-length codes, expands them into a bit stream and packs it MSB-first into DATA_W-bit RAM words, starting at an arbitrary word address and bit index.
- Partial words at either end are merged with existing RAM contents by read-modify-write. Full words are written directly.
- Sits between the input DMA/code FIFO and the feature-map RAM port.

Parameters:
- DATA_W, 16: RAM word width in bits (power of 2, >=8).
- ADDR_W, 16: RAM word address width.
- CODE_W, 8: code width. MSB = bit value, low CODE_W-1 bits = run length (0..2^(CODE_W-1)-1).
- BIDX_W, $clog2(DATA_W): bit index width.

Ports:
- clk  in  1  clock.
- RST  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a job; ignored while busy.
- start_addr  in  ADDR_W  first word address.
- start_bit  in  BIDX_W  first bit to write (DATA_W-1 = word-aligned).
- code_valid  in  1  code present.
- code_ready  out  1  code accepted when valid&ready.
- code  in  CODE_W  run-length code.
- flush  in  1  level; end of job requested.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse at job end.
- end_addr  out  ADDR_W  address of next word to write.
- end_bit  out  BIDX_W  next bit index to write.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, valid exactly 1 cycle after ram_rd.
- ram_rd  out  1  read strobe.
- ram_wr  out  1  write strobe.

Behaviour:
- All outputs are registered. On RST=0 at a clk edge:
  - state=IDLE.
  - busy, done, code_ready, ram_rd, ram_wr, ram_addr, ram_wdata, end_addr all 0.
  - end_bit=DATA_W-1.
  - Internal word/mask/run registers cleared.
- Reset mid-job aborts immediately. No further RAM strobes are issued after the reset edge.
- Fill order: bit_idx counts down from DATA_W-1 to 0, then wraps to DATA_W-1 with cur_addr+1. cur_addr wraps modulo 2^ADDR_W.
- Internal registers: word_buf, mask (1 = bit written this job), run_val, run_left.
- States:
  - IDLE: start -> RUN. Loads cur_addr=start_addr, bit_idx=start_bit, mask=0; busy=1.
  - RUN:
    - code_ready=1 iff run_left==0 and the word is not full. Accepting a code loads run_val/run_left.
    - While run_left>0, each cycle fill n=min(run_left, bit_idx+1) bits [bit_idx : bit_idx-n+1] with run_val, set the same mask bits, and subtract n from both run_left and bit_idx.
    - When bit 0 is filled: mask all ones -> WR; otherwise -> RD.
    - Zero-length codes are accepted and have no effect.
  - WR: ram_wr=1, ram_addr=cur_addr, ram_wdata=word_buf. Then cur_addr+1, bit_idx=DATA_W-1, mask=0; return to RUN, or to DONE if flushing.
  - RD: ram_rd=1 at cur_addr -> MERGE.
  - MERGE: ram_wr=1, ram_wdata=(word_buf&mask)|(ram_rdata&~mask). Then advance as in WR if the word was full; otherwise (flush of a partial word) keep cur_addr/bit_idx -> DONE.
  - DONE: done=1 for one cycle; end_addr=cur_addr, end_bit=bit_idx; busy=0 -> IDLE.
- Flush:
  - Acted on in RUN only when run_left==0 and code_valid==0; a pending code always wins.
  - Flush with mask!=0 -> RD.
  - Flush with mask==0 -> DONE directly, no RAM access.
- code_ready=0 in IDLE, RD, WR, MERGE and DONE.
- end_addr and end_bit hold from done until the next start.
- Write rule: a word is never written unless at least one of its bits was produced this job. A word partial on both sides (start and flush in the same word) is a single RMW.

Optional Feature:
- Macro: RLE_DECOMP_STATS_EN.
- Defined: adds outputs bit_count [31:0] (total bits produced this job, cleared on start) and words_written [ADDR_W-1:0] (RAM writes this job). Both reset to 0.
- Undefined: ports and counters are absent. Core behaviour is identical.

Decomposition:
- Package rle_decomp_pkg: state enum (IDLE, RUN, RD, MERGE, WR, DONE), code field-split helpers, default width constants.
- One sub-module, rle_bit_packer: a combinational mask/fill generator taking bit_idx, n and run_val.

Test Plan (DATA_W=16, CODE_W=8, code 0xNN = value bit7, length bits6:0):
1. start addr 0x0010 bit 15, code 0x90, flush -> one write 0x0010=0xFFFF, no ram_rd; done with end_addr 0x0011, end_bit 15.
2. RAM[0x20]=0xABCD; start 0x0020 bit 7, code 0x84, flush -> rd 0x20 then wr 0xABFD; end_addr 0x20, end_bit 3.
3. RAM[2]=0x1234; start 0x0 bit 15, code 0xA8 (40 ones), flush -> wr 0x0=0xFFFF, wr 0x1=0xFFFF, rd 0x2, wr 0x2=0xFF34; end 0x2 bit 7.
4. codes 0x80, 0x00, 0x08, 0x88 offered back-to-back at word start -> zero-length code absorbed; word = 0x00FF written once; code_ready low during the WR cycle.
5. start 0xFFFF bit 15, code 0xA0 (32 ones) -> writes to 0xFFFF then 0x0000, both 0xFFFF; end_addr 0x0001.
6. Assert RST=0 during RD of scenario 2 -> next cycle all outputs at reset values; no ram_wr; new start then runs normally.
